ll_keypad: RTL
==============

LL_KEYPAD -- requirements
Module: ll_keypad

Interface
REQ-001 Parameter DEB_CYCLES, default 1, number of consecutive stable synchronized samples that qualify a press (legal range 1..15).
REQ-002 Parameter THRUST_INIT, default 4'd5, thrust value loaded on reset.
REQ-003 hz100  input  1  system clock, all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in  input  20  raw push buttons; [9:0] = thrust digits 0-9, [19] ALT, [18] VEL, [17] GAS, [16] THR, [15:10] ignored.
REQ-006 frozen  input  1  lander landed or crashed; suppresses thrust updates while high.
REQ-007 thrust  output  4  registered thrust setting, 0..9, feeds the lander core.
REQ-008 mode  output  2  registered display select: 0 ALT, 1 VEL, 2 GAS, 3 THR.
REQ-009 thrust_evt  output  1  one-cycle pulse on the edge thrust is written.
REQ-010 mode_evt  output  1  one-cycle pulse on the edge mode is written.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 in SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The synchronized vector SHALL be priority-encoded each cycle into a 5-bit code: highest-index set bit among [19:16] and [9:0] wins; [15:10] alone yields "none".
REQ-014 The FSM SHALL have states IDLE, DEBOUNCE, HELD and RELEASE.
REQ-015 IDLE: code none -> stay; code valid -> latch as candidate, count=1, go DEBOUNCE.
REQ-016 DEBOUNCE: code equals candidate -> count+1; code differs and is valid -> relatch candidate, count=1; code none -> IDLE.
REQ-017 When the candidate has been seen DEB_CYCLES consecutive cycles, the block SHALL fire once and go HELD.
REQ-018 The first raw-high sample to outputs-updated latency SHALL be exactly 2+DEB_CYCLES rising edges; default is 3.
REQ-019 Fire on digit d with frozen low SHALL set thrust=d and pulse thrust_evt.
REQ-020 Fire on digit with frozen high SHALL leave thrust unchanged with no pulse.
REQ-021 Fire on a mode button SHALL set mode per REQ-008 and pulse mode_evt regardless of frozen.
REQ-022 HELD: any valid code -> stay with no further events; code none -> RELEASE, count=1.
REQ-023 RELEASE: none for DEB_CYCLES cycles -> IDLE; any valid code -> HELD. A bounce SHALL never create a second event.
REQ-024 Pressing a second button while one is held SHALL produce no event until all buttons are released per REQ-023.
REQ-025 thrust_evt and mode_evt SHALL never be high in the same cycle.
REQ-026 Outputs SHALL be driven only from registers, with no combinational path from in to any output.

Reset
REQ-027 While reset_n is low: thrust=THRUST_INIT, mode=0 (ALT), thrust_evt=0, mode_evt=0, busy=0, FSM=IDLE, synchronizer flops=0, count=0.
REQ-028 Reset asserted mid-press SHALL abort the press.
REQ-029 After reset_n rises, a button still held SHALL be treated as a new press and fire after 2+DEB_CYCLES edges.

Structure
REQ-030 Shared package ll_pkg SHALL hold the mode enum (MODE_ALT, MODE_VEL, MODE_GAS, MODE_THR), the FSM state enum, the key-code encoding and the THRUST_INIT default.
REQ-031 One sub-module, ll_sync (parameterized-width 2-flop synchronizer, async active-low reset), SHALL be instantiated for in[19:0].
REQ-032 The priority encoder, FSM and output registers SHALL live in ll_keypad.

Verification
REQ-033 Reset, then idle: thrust=5, mode=0, both evt=0, busy=0.
REQ-034 Hold in[9] for 3 edges then release for 3 edges: thrust=9 on the 3rd edge, thrust_evt high exactly 1 cycle, busy returns 0.
REQ-035 Hold in[18] for 10 edges: mode=1, mode_evt pulses exactly once.
REQ-036 Assert in[2] and in[17] together: mode=2 with mode_evt pulse, thrust stays 5.
REQ-037 Press in[5] and 2 edges later add in[7]; release both: thrust=5, single event. Toggle in[5] 1-cycle glitches with DEB_CYCLES=3: no event.
REQ-038 frozen=1, press in[0]: thrust unchanged, no thrust_evt. Then press in[16]: mode=3. Assert reset_n low mid-press: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ll_pkg.sv
// ll_pkg -- shared definitions for the lunar-lander keypad front end.
//   mode_e      : display select driven on ll_keypad.mode
//   state_e     : keypad press-tracking FSM states
//   key_code_t  : 5-bit priority-encoded key (0..9 digits, 16..19 mode keys, KEY_NONE)
//   THRUST_INIT_DEF : thrust value loaded on reset
package ll_pkg;

  typedef enum logic [1:0] {
    MODE_ALT = 2'd0,
    MODE_VEL = 2'd1,
    MODE_GAS = 2'd2,
    MODE_THR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam int unsigned KEY_W = 5;
  typedef logic [KEY_W-1:0] key_code_t;

  // Key codes equal the button's bit index in the input vector.
  localparam key_code_t KEY_NONE = 5'd31;
  localparam key_code_t KEY_THR  = 5'd16;
  localparam key_code_t KEY_GAS  = 5'd17;
  localparam key_code_t KEY_VEL  = 5'd18;
  localparam key_code_t KEY_ALT  = 5'd19;

  // Buttons that take part in encoding: [19:16] and [9:0].
  localparam logic [19:0] KEY_MASK = 20'hF_03FF;

  localparam logic [3:0] THRUST_INIT_DEF = 4'd5;

  function automatic logic key_is_digit(input key_code_t k);
    return (k <= 5'd9);
  endfunction

  function automatic mode_e key_to_mode(input key_code_t k);
    mode_e m;
    case (k)
      KEY_VEL: m = MODE_VEL;
      KEY_GAS: m = MODE_GAS;
      KEY_THR: m = MODE_THR;
      default: m = MODE_ALT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ll_sync.sv
// ll_sync -- parameterized-width two-flop synchronizer.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input vector
//   q     : synchronized vector, two rising edges behind d
module ll_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ll_keypad.sv
// ll_keypad -- debounced keypad for the lunar lander.
//   hz100      : system clock, rising-edge active
//   reset_n    : asynchronous active-low reset
//   in[19:0]   : raw buttons; [9:0] thrust digits, [19] ALT, [18] VEL,
//                [17] GAS, [16] THR, [15:10] ignored
//   frozen     : lander finished; thrust digits are ignored while high
//   thrust     : registered thrust setting 0..9
//   mode       : registered display select (ll_pkg::mode_e)
//   thrust_evt : one-cycle pulse when thrust is written
//   mode_evt   : one-cycle pulse when mode is written
//   busy       : high whenever the press tracker is not idle
// A press is accepted once the same key has been seen DEB_CYCLES
// consecutive synchronized cycles; nothing else is accepted until every
// button has been released long enough to pass the release filter.
module ll_keypad
  import ll_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1,
  parameter logic [3:0]  THRUST_INIT = THRUST_INIT_DEF
) (
  input  logic        hz100,
  input  logic        reset_n,
  input  logic [19:0] in,
  input  logic        frozen,
  output logic [3:0]  thrust,
  output logic [1:0]  mode,
  output logic        thrust_evt,
  output logic        mode_evt,
  output logic        busy
);

  localparam logic [3:0] DEB_L = 4'(DEB_CYCLES);

  logic [19:0] in_sync;
  key_code_t   key_code;
  logic        code_valid;

  state_e      state_q, state_d;
  key_code_t   cand_q, cand_d;
  logic [3:0]  count_q, count_d;
  logic        fire;

  logic [3:0]  thrust_q, thrust_d;
  mode_e       mode_q, mode_d;
  logic        thrust_evt_q, thrust_evt_d;
  logic        mode_evt_q, mode_evt_d;
  logic        busy_q, busy_d;

  ll_sync #(.W(20)) u_sync (
    .clk   (hz100),
    .rst_n (reset_n),
    .d     (in),
    .q     (in_sync)
  );

  // Priority encoder: later (higher-index) hits overwrite earlier ones.
  always_comb begin
    key_code = KEY_NONE;
    for (int i = 0; i < 20; i++) begin
      if (in_sync[i] && KEY_MASK[i]) key_code = key_code_t'(i);
    end
  end

  assign code_valid = (key_code != KEY_NONE);

  // Press tracker. A fire always coincides with key_code being the
  // accepted candidate, so the output logic uses key_code directly.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (code_valid) begin
          cand_d  = key_code;
          count_d = 4'd1;
          // With a one-sample filter the first sight already qualifies.
          if (DEB_L <= 4'd1) begin
            fire    = 1'b1;
            state_d = ST_HELD;
            count_d = 4'd0;
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (!code_valid) begin
          state_d = ST_IDLE;
          count_d = 4'd0;
        end else if (key_code == cand_q) begin
          count_d = count_q + 4'd1;
          if (count_d >= DEB_L) begin
            fire    = 1'b1;
            state_d = ST_HELD;
            count_d = 4'd0;
          end
        end else begin
          cand_d  = key_code;
          count_d = 4'd1;
        end
      end
      ST_HELD: begin
        if (!code_valid) begin
          state_d = ST_RELEASE;
          count_d = 4'd1;
        end
      end
      ST_RELEASE: begin
        if (code_valid) begin
          // Bounce while releasing: back to HELD, never a new event.
          state_d = ST_HELD;
          count_d = 4'd0;
        end else if ((count_q + 4'd1) >= DEB_L) begin
          state_d = ST_IDLE;
          count_d = 4'd0;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  // Output updates; a fire on one key produces at most one of the two events.
  always_comb begin
    thrust_d     = thrust_q;
    mode_d       = mode_q;
    thrust_evt_d = 1'b0;
    mode_evt_d   = 1'b0;
    if (fire) begin
      if (key_is_digit(key_code)) begin
        if (!frozen) begin
          thrust_d     = key_code[3:0];
          thrust_evt_d = 1'b1;
        end
      end else begin
        mode_d     = key_to_mode(key_code);
        mode_evt_d = 1'b1;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cand_q       <= KEY_NONE;
      count_q      <= 4'd0;
      thrust_q     <= THRUST_INIT;
      mode_q       <= MODE_ALT;
      thrust_evt_q <= 1'b0;
      mode_evt_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      count_q      <= count_d;
      thrust_q     <= thrust_d;
      mode_q       <= mode_d;
      thrust_evt_q <= thrust_evt_d;
      mode_evt_q   <= mode_evt_d;
      busy_q       <= busy_d;
    end
  end

  assign thrust     = thrust_q;
  assign mode       = mode_q;
  assign thrust_evt = thrust_evt_q;
  assign mode_evt   = mode_evt_q;
  assign busy       = busy_q;

endmodule
